// File: rtl/store_queue_ctrl.sv
// store_queue_ctrl: store buffer and data-bus write sequencer.
// Stores from MEM (SB/SH/SW) are lane-aligned, given byte strobes, and queued
// in a circular FIFO. The queue drains in order with one bus write in flight
// at a time. Loads whose word address matches a pending store are flagged.
//
// Optional build macro: STORE_MERGE_EN (merge a store into the tail entry
// when both fall in the same word and the tail is not the in-flight head).
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   st_valid/st_ready/st_addr/st_data/st_size   store input handshake
//   ld_check/ld_addr/ld_conflict     combinational load hazard check
//   empty                            queue empty and bus idle
//   data_req/data_wr/data_size/data_addr/data_wdata/data_wstrb  bus request
//   data_addr_ok/data_data_ok        bus accept / completion
module store_queue_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        empty,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    entry_t             q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    state_t             state, state_nxt;

    logic [31:0]        al_wdata;
    logic [3:0]         al_wstrb;
    entry_t             new_ent;
    logic               push, alloc, pop, merge_hit;
    logic               unused_ld_lsbs;

    assign unused_ld_lsbs = ^ld_addr[1:0];

    // Byte-lane alignment of the incoming store
    always_comb begin
        al_wdata = st_data;
        al_wstrb = 4'b1111;
        case (st_size)
            2'b00: begin
                al_wdata = st_data << {st_addr[1:0], 3'b000};
                al_wstrb = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                if (st_addr[1]) begin
                    al_wdata = st_data << 16;
                    al_wstrb = 4'b1100;
                end else begin
                    al_wstrb = 4'b0011;
                end
            end
            default: ;
        endcase
    end

    assign new_ent = '{addr: st_addr, size: st_size, wdata: al_wdata, wstrb: al_wstrb};

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] tail_ptr;
    entry_t           merge_ent;

    assign tail_ptr = wr_ptr - PTR_W'(1);
    // The in-flight head must stay stable on the bus, so never merge into it
    assign merge_hit = (count != '0)
                     && (q[tail_ptr].addr[31:2] == st_addr[31:2])
                     && !((tail_ptr == rd_ptr) && (state != S_IDLE));

    // New strobed bytes overwrite the tail; result becomes a word-aligned entry
    always_comb begin
        merge_ent       = q[tail_ptr];
        merge_ent.addr  = {q[tail_ptr].addr[31:2], 2'b00};
        merge_ent.size  = 2'b10;
        merge_ent.wstrb = q[tail_ptr].wstrb | al_wstrb;
        for (int unsigned b = 0; b < 4; b++) begin
            if (al_wstrb[b]) merge_ent.wdata[8*b +: 8] = al_wdata[8*b +: 8];
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    assign st_ready = (count != CNT_W'(DEPTH)) | merge_hit;
    assign push     = st_valid & st_ready;
    assign alloc    = push & ~merge_hit;
    assign pop      = ((state == S_REQ) & data_addr_ok & data_data_ok)
                    | ((state == S_WAIT) & data_data_ok);

    // Entry storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (alloc) begin
            q[wr_ptr] <= new_ent;
        end
`ifdef STORE_MERGE_EN
        else if (push) begin
            q[tail_ptr] <= merge_ent;
        end
`endif
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (alloc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({alloc, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Bus FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Bus FSM next state; an enqueue into an idle queue requests next cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if ((count != '0) || push) state_nxt = S_REQ;
            S_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) state_nxt = (count > CNT_W'(1)) ? S_REQ : S_IDLE;
                    else              state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (data_data_ok) state_nxt = (count > CNT_W'(1)) ? S_REQ : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load hazard: any valid entry (head included) in the same word
    always_comb begin
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count)
                && (q[i].addr[31:2] == ld_addr[31:2]))
                ld_conflict = ld_check;
        end
    end

    assign empty      = (count == '0) && (state == S_IDLE);
    assign data_req   = (state == S_REQ);
    assign data_wr    = data_req;
    assign data_addr  = q[rd_ptr].addr;
    assign data_size  = q[rd_ptr].size;
    assign data_wdata = q[rd_ptr].wdata;
    assign data_wstrb = q[rd_ptr].wstrb;

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Self-checking bench for store_queue_ctrl: expected bus writes are queued
// when stores are accepted and compared when the DUT's request is accepted.
module tb_store_queue_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [1:0]  st_size;
    logic        ld_check, ld_conflict;
    logic [31:0] ld_addr;
    logic        empty, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   auto_bus = 1'b0;

    store_queue_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size),
        .ld_check(ld_check), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .empty(empty), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic txn_t exp_txn(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        txn_t t;
        t.addr = a;
        t.size = sz;
        case (sz)
            2'b00: begin t.wdata = d << (8 * a[1:0]); t.wstrb = 4'b0001 << a[1:0]; end
            2'b01: begin
                t.wdata = a[1] ? (d << 16) : d;
                t.wstrb = a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin t.wdata = d; t.wstrb = 4'b1111; end
        endcase
        return t;
    endfunction

    // Advance one cycle; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_bus) begin
            data_addr_ok = data_req;
            data_data_ok = data_req;
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d, input bit merge);
        txn_t t, old;
        int   budget = 20;
        st_valid = 1'b1; st_addr = a; st_size = sz; st_data = d;
        #1;
        while (!st_ready && budget > 0) begin
            tick();
            #1;
            budget--;
        end
        if (!st_ready) begin
            check_eq("st_ready_timeout", st_ready, 1'b1);
        end else begin
            t = exp_txn(a, sz, d);
            if (merge && sb.size() != 0) begin
                old = sb[$];
                for (int b = 0; b < 4; b++)
                    if (t.wstrb[b]) old.wdata[8*b +: 8] = t.wdata[8*b +: 8];
                old.wstrb = old.wstrb | t.wstrb;
                old.size  = 2'b10;
                old.addr  = {old.addr[31:2], 2'b00};
                sb[$] = old;
            end else begin
                sb.push_back(t);
            end
        end
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 60;
        auto_bus = 1'b1;
        data_addr_ok = data_req;
        data_data_ok = data_req;
        while (!empty && budget > 0) begin
            tick();
            budget--;
        end
        check_eq("drain_empty", empty, 1'b1);
        auto_bus = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    // Scoreboard: compare each bus write as it is accepted
    always @(negedge clk) begin
        if (resetn && data_req && data_addr_ok) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                txn_t e;
                e = sb.pop_front();
                check_eq("bus_addr", data_addr, e.addr);
                check_eq("bus_size", 32'(data_size), 32'(e.size));
                check_eq("bus_wdata", data_wdata, e.wdata);
                check_eq("bus_wstrb", 32'(data_wstrb), 32'(e.wstrb));
                check_eq("bus_wr", data_wr, 1'b1);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
        ld_check = 1'b1; ld_addr = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_data_req", data_req, 1'b0);
        check_eq("rst_st_ready", st_ready, 1'b1);
        check_eq("rst_empty", empty, 1'b1);
        check_eq("rst_ld_conflict", ld_conflict, 1'b0);
        resetn = 1'b1;
        ld_check = 1'b0;
        tick();

        // 1: byte store at lane 3, request the next cycle
        do_store(32'h0000_1003, 2'b00, 32'h0000_00AB, 1'b0);
        check_eq("t1_req", data_req, 1'b1);
        check_eq("t1_addr", data_addr, 32'h0000_1003);
        check_eq("t1_wdata", data_wdata, 32'hAB00_0000);
        check_eq("t1_wstrb", 32'(data_wstrb), 32'h8);
        check_eq("t1_not_empty", empty, 1'b0);
        drain();

        // 2: halfword upper and lower
        do_store(32'h0000_2002, 2'b01, 32'h0000_1234, 1'b0);
        check_eq("t2_hi_wdata", data_wdata, 32'h1234_0000);
        check_eq("t2_hi_wstrb", 32'(data_wstrb), 32'hC);
        drain();
        do_store(32'h0000_2000, 2'b01, 32'h0000_1234, 1'b0);
        check_eq("t2_lo_wdata", data_wdata, 32'h0000_1234);
        check_eq("t2_lo_wstrb", 32'(data_wstrb), 32'h3);
        drain();

        // 3: fill the queue with the bus stalled, then a single pop
        for (int i = 0; i < 4; i++)
            do_store(32'h0000_5000 + 32'(4 * i), 2'b10, 32'hA0A0_0000 + 32'(i), 1'b0);
        check_eq("t3_full_ready", st_ready, 1'b0);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check_eq("t3_wait_req", data_req, 1'b0);
        check_eq("t3_wait_ready", st_ready, 1'b0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        check_eq("t3_pop_ready", st_ready, 1'b1);
        check_eq("t3_next_req", data_req, 1'b1);
        check_eq("t3_next_addr", data_addr, 32'h0000_5004);
        drain();

        // 4: same-cycle accept and completion, back-to-back requests
        do_store(32'h0000_6000, 2'b10, 32'h1111_1111, 1'b0);
        do_store(32'h0000_6004, 2'b10, 32'h2222_2222, 1'b0);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        check_eq("t4_req_held", data_req, 1'b1);
        check_eq("t4_next_addr", data_addr, 32'h0000_6004);
        drain();

        // 5: load hazard against a pending store
        do_store(32'h0000_3004, 2'b10, 32'hDEAD_BEEF, 1'b0);
        ld_check = 1'b1; ld_addr = 32'h0000_3007;
        #1;
        check_eq("t5_conflict", ld_conflict, 1'b1);
        ld_addr = 32'h0000_3008;
        #1;
        check_eq("t5_other_word", ld_conflict, 1'b0);
        ld_addr = 32'h0000_3007;
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check_eq("t5_inflight_conflict", ld_conflict, 1'b1);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        check_eq("t5_done_conflict", ld_conflict, 1'b0);
        // A store enqueued in the same cycle does not count yet
        ld_addr = 32'h0000_7000;
        st_valid = 1'b1; st_addr = 32'h0000_7000; st_size = 2'b10; st_data = 32'h7;
        #1;
        check_eq("t5_same_cycle", ld_conflict, 1'b0);
        check_eq("t5_same_ready", st_ready, 1'b1);
        sb.push_back(exp_txn(32'h0000_7000, 2'b10, 32'h7));
        tick();
        st_valid = 1'b0;
        check_eq("t5_after_enq", ld_conflict, 1'b1);
        ld_check = 1'b0;
        drain();

        // 6: byte stores to one word behind an in-flight head
        do_store(32'h0000_8000, 2'b10, 32'h8888_8888, 1'b0);
        do_store(32'h0000_4000, 2'b00, 32'h0000_0011, 1'b0);
`ifdef STORE_MERGE_EN
        do_store(32'h0000_4001, 2'b00, 32'h0000_0022, 1'b1);
        check_eq("t6_merged_word", sb[$].wdata, 32'h0000_2211);
        check_eq("t6_merged_strb", 32'(sb[$].wstrb), 32'h3);
`else
        do_store(32'h0000_4001, 2'b00, 32'h0000_0022, 1'b0);
`endif
        drain();
        check_eq("sb_leftover", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
